// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and lane helpers for the load/store data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic logic [3:0] be_from(size_e size, logic [1:0] off);
    case (size)
      SZ_B:    be_from = 4'b0001 << off;
      SZ_H:    be_from = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be_from = 4'b1111;
      default: be_from = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] word, size_e size, logic [1:0] off,
                                           logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    load_ext = {{24{b[7] & ~is_unsigned}}, b};
      SZ_H:    load_ext = {{16{h[15] & ~is_unsigned}}, h};
      SZ_W:    load_ext = word;
      default: load_ext = '0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// rtl/data_mem_lsu_if.sv - request/response handshake bundle between the memory stage and the LSU.
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-organised storage with per-byte-lane writes and asynchronous read.
module dmem_array #(
  parameter int DEPTH = 1024,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - single-outstanding load/store memory with fault check, lane steering and
// configurable response latency.
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_lsu_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e        state;
  logic [3:0]    cnt;
  size_e         size;
  logic          accept;
  logic          bad_shape;
  logic          in_range;
  logic          fault;
  logic [31:0]   word_off;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdata_lanes;
  logic [31:0]   rdata_word;

  assign size     = size_e'(bus.req_size);
  assign accept   = bus.req_valid && bus.req_ready;
  assign word_off = (bus.req_addr - BASE_ADDR) >> 2;
  assign idx      = word_off[AW-1:0];
  // Range test on the word offset avoids overflow when BASE_ADDR + 4*DEPTH reaches 2^32.
  assign in_range = (bus.req_addr >= BASE_ADDR) && (word_off < 32'(DEPTH));

  always_comb begin
    bad_shape = 1'b0;
    case (size)
      SZ_H:    bad_shape = bus.req_addr[0];
      SZ_W:    bad_shape = |bus.req_addr[1:0];
      SZ_ILL:  bad_shape = 1'b1;
      default: bad_shape = 1'b0;
    endcase
  end

  assign fault = bad_shape || !in_range;
  assign be    = (accept && bus.req_we && !fault) ? be_from(size, bus.req_addr[1:0]) : 4'b0000;

  always_comb begin
    wdata_lanes = bus.req_wdata;
    case (size)
      SZ_B:    wdata_lanes = {4{bus.req_wdata[7:0]}};
      SZ_H:    wdata_lanes = {2{bus.req_wdata[15:0]}};
      default: wdata_lanes = bus.req_wdata;
    endcase
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .be    (be),
    .idx   (idx),
    .wdata (wdata_lanes),
    .rdata (rdata_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.rsp_err   <= fault;
            bus.rsp_rdata <= (fault || bus.req_we) ? 32'h0 :
                             load_ext(rdata_word, size, bus.req_addr[1:0], bus.req_unsigned);
            bus.req_ready <= 1'b0;
            if (LATENCY > 1) begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end else begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - scoreboard bench for data_mem_lsu at LATENCY=1 and LATENCY=4.
module tb_data_mem_lsu;
  import dmem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_lsu_if if1 ();
  data_mem_lsu_if if4 ();

  data_mem_lsu #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );
  data_mem_lsu #(.DEPTH(64), .BASE_ADDR(32'h0000_0100), .LATENCY(4)) dut4 (
    .clk (clk), .rst (rst), .bus (if4.slave)
  );

  logic        sel = 1'b0;
  logic        valid = 1'b0, rready = 1'b1, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;

  assign if1.req_valid = valid && !sel;
  assign if4.req_valid = valid && sel;
  assign if1.rsp_ready = sel ? 1'b1 : rready;
  assign if4.rsp_ready = sel ? rready : 1'b1;
  assign if1.req_we = we;       assign if4.req_we = we;
  assign if1.req_size = size;   assign if4.req_size = size;
  assign if1.req_unsigned = uns; assign if4.req_unsigned = uns;
  assign if1.req_addr = addr;   assign if4.req_addr = addr;
  assign if1.req_wdata = wdata; assign if4.req_wdata = wdata;

  wire        m_req_ready = sel ? if4.req_ready : if1.req_ready;
  wire        m_rsp_valid = sel ? if4.rsp_valid : if1.rsp_valid;
  wire [31:0] m_rsp_rdata = sel ? if4.rsp_rdata : if1.rsp_rdata;
  wire        m_rsp_err   = sel ? if4.rsp_err   : if1.rsp_err;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic access(string tag, logic w, logic [1:0] sz, logic u, logic [31:0] a,
                        logic [31:0] d, logic [31:0] exp_rd, logic exp_err, int hold, int lat);
    exp_t e;
    int   k;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(m_req_ready), 32'd1);
    rready = (hold == 0);
    we = w; size = sz; uns = u; addr = a; wdata = d; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    k = 1;
    while (!m_rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, 32'(k), 32'(lat));
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      check({tag, ".hold_valid"}, 32'(m_rsp_valid), 32'd1);
      check({tag, ".hold_rdata"}, m_rsp_rdata, e.rdata);
      check({tag, ".hold_req_ready"}, 32'(m_req_ready), 32'd0);
      @(negedge clk);
    end
    check({tag, ".rdata"}, m_rsp_rdata, e.rdata);
    check({tag, ".err"}, 32'(m_rsp_err), 32'(e.err));
    rready = 1'b1;
    @(negedge clk);
    check({tag, ".turnaround"}, 32'(m_req_ready), 32'd1);
    check({tag, ".valid_drop"}, 32'(m_rsp_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst.req_ready1", 32'(if1.req_ready), 32'd1);
    check("rst.rsp_valid1", 32'(if1.rsp_valid), 32'd0);
    check("rst.rsp_rdata4", if4.rsp_rdata, 32'd0);
    check("rst.rsp_err4", 32'(if4.rsp_err), 32'd0);
    rst = 1'b0;

    sel = 1'b0;
    access("st_w",       1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0, 1);
    access("ld_w",       1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0, 1);
    access("ld_b_s13",   1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 0, 1);
    access("ld_b_u12",   1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        32'h000000AD, 1'b0, 0, 1);
    access("ld_h_s12",   1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 0, 1);
    access("st_h12",     1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA1234, 32'h0,        1'b0, 0, 1);
    access("ld_w_h",     1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1234BEEF, 1'b0, 0, 1);
    access("st_b11",     1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF77, 32'h0,        1'b0, 0, 1);
    access("ld_w_b",     1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h123477EF, 1'b0, 0, 1);
    access("st_w0",      1'b1, 2'b10, 1'b0, 32'h0,  32'hA5A5A5A5, 32'h0,        1'b0, 0, 1);
    access("f_st_w11",   1'b1, 2'b10, 1'b0, 32'h11, 32'h11111111, 32'h0,        1'b1, 0, 1);
    access("f_st_h13",   1'b1, 2'b01, 1'b0, 32'h13, 32'h00002222, 32'h0,        1'b1, 0, 1);
    access("f_st_size3", 1'b1, 2'b11, 1'b0, 32'h10, 32'h33333333, 32'h0,        1'b1, 0, 1);
    access("f_st_oor",   1'b1, 2'b10, 1'b0, 32'h1000, 32'h55555555, 32'h0,      1'b1, 0, 1);
    access("f_ld_w11",   1'b0, 2'b10, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 0, 1);
    access("ld_w_after", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h123477EF, 1'b0, 0, 1);
    access("ld_w0",      1'b0, 2'b10, 1'b0, 32'h0,  32'h0,        32'hA5A5A5A5, 1'b0, 0, 1);
    access("ld_b_s10",   1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 0, 1);
    access("ld_h_u10",   1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h000077EF, 1'b0, 0, 1);
    access("ld_h_s12b",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h00001234, 1'b0, 0, 1);

    sel = 1'b1;
    access("l4_st_w140", 1'b1, 2'b10, 1'b0, 32'h140, 32'h89ABCDEF, 32'h0,       1'b0, 0, 4);
    access("l4_ld_bp",   1'b0, 2'b10, 1'b0, 32'h140, 32'h0,       32'h89ABCDEF, 1'b0, 3, 4);
    access("l4_st_w100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h01020304, 32'h0,       1'b0, 0, 4);
    access("l4_f_end",   1'b1, 2'b00, 1'b0, 32'h200, 32'h000000FF, 32'h0,       1'b1, 0, 4);
    access("l4_f_below", 1'b0, 2'b10, 1'b0, 32'hFC,  32'h0,       32'h0,        1'b1, 0, 4);
    access("l4_ld_w100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0,       32'h01020304, 1'b0, 0, 4);
    access("l4_ld_b_u",  1'b0, 2'b00, 1'b1, 32'h143, 32'h0,       32'h00000089, 1'b0, 0, 4);

    @(negedge clk);
    we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h120; wdata = 32'hCAFEF00D; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("rstw.busy", 32'(if4.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw.rsp_valid", 32'(if4.rsp_valid), 32'd0);
    check("rstw.req_ready_async", 32'(if4.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstw.req_ready", 32'(if4.req_ready), 32'd1);
    check("rstw.rsp_valid_after", 32'(if4.rsp_valid), 32'd0);
    access("l4_ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h120, 32'h0, 32'hCAFEF00D, 1'b0, 0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
